jt08_adpcm_rmul_mch: RTL and testbench
======================================

Name: jt08_adpcm_rmul_mch

Overview:
- Multi-channel, parametrised successor to the ADPCM fractional shift-add multiplier.
- Computes d = a*b/2^DW with full-precision accumulation, selectable rounding, optional signed multiplicand and 1/2/4 bits of b per step.
- Runs a fixed latency with a valid/ready request handshake.
- Keeps a per-channel result bank so the ADPCM step/volume logic can time-share one engine across channels.

Parameters:
- DW, 16, data width of a, b, d; must be a multiple of RADIX.
- CH, 6, channel count; result bank depth.
- CW, 3, channel index width; must satisfy 2^CW >= CH.
- RADIX, 1, bits of b consumed per cen step; legal values 1, 2, 4.
- SIGNED, 0, 1 = a is two's complement and d is signed; b is always an unsigned fraction.
- ROUND, 0, 0 = floor; 1 = round half up (add 2^(DW-1) before the final shift).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- cen  in  1  clock enable; all state advances only on clk edges with cen=1.
- in_valid  in  1  request present.
- in_ready  out  1  engine can accept a request this cycle.
- in_ch  in  CW  channel tag of the request.
- a  in  DW  multiplicand.
- b  in  DW  unsigned fractional multiplier (value b/2^DW).
- out_valid  out  1  result available; high for exactly one cen period.
- out_ch  out  CW  channel tag of d.
- d  out  DW  result.
- bank  out  CH*DW  last result per channel; channel n occupies bits [n*DW+DW-1 : n*DW].
- busy  out  1  high while in the RUN state.

Behaviour:
- Reset (rst=1 at a clk edge, regardless of cen):
  - state=IDLE; in_ready=1; out_valid=0; busy=0; d=0; out_ch=0; every bank entry=0.
  - Any in-flight operation is discarded and produces no output.
- Arithmetic:
  - Define P = A*b, with A = a read as signed if SIGNED=1, unsigned otherwise.
  - P is exact, held in 2*DW+1 bits.
  - ROUND=0: d = floor(P/2^DW). Floor is toward minus infinity in signed mode.
  - ROUND=1: d = floor((P+2^(DW-1))/2^DW).
  - The result always fits in DW bits, so no saturation logic exists. Limit cases: unsigned max -> 2^DW-2; signed minimum -> -2^(DW-1) or -2^(DW-1)+1.
  - No truncation happens per step; the accumulator is wide enough for the exact product.
- Let N = DW/RADIX.
- States:
  - IDLE: in_ready=1. On a cen edge with in_valid=1, latch a, b and in_ch, load step count N, clear the accumulator, and go to RUN.
  - RUN: busy=1, in_ready=0. Each cen edge consumes RADIX bits of b and decrements the count. The edge that takes the count from 1 to 0 goes to DONE.
  - DONE: out_valid=1; d and out_ch hold the result and tag; bank[out_ch] is written with d on the DONE-entry edge. in_ready=1.
    - On the next cen edge: go to RUN if in_valid (back-to-back accept), otherwise IDLE.
    - out_valid drops at that edge in either case.
- Latency:
  - Accept at cen edge k; out_valid is high from edge k+N until edge k+N+1 (cen edges).
  - Latency is fixed and independent of the b value. b=0 still takes N steps and returns 0. There is no early exit.
  - Sustained throughput is one result per N+1 cen edges.
- cen=0:
  - All registers hold, including the step count.
  - out_valid stays high for the whole stalled period when in DONE.
  - in_valid is ignored on edges where cen=0.
- in_ch >= CH: the operation runs and d/out_ch are reported, but no bank entry is written.
- Inputs a and b may change freely after acceptance; only the latched copies are used.
- d and out_ch hold their last values while in IDLE/RUN until the next DONE.

Test Plan:
- DW=16, RADIX=1, SIGNED=0, ROUND=0: a=0x8000, b=0x8000, in_ch=2 -> after 16 cen edges, out_valid=1 for one cen period, d=0x4000, out_ch=2, bank[2]=0x4000, other bank entries 0.
- a=0xFFFF, b=0xFFFF: ROUND=0 -> d=0xFFFE; ROUND=1 -> d=0xFFFE. Separately a=0x0003, b=0x8000: ROUND=0 -> d=0x0001; ROUND=1 -> d=0x0002.
- SIGNED=1: a=0x8000, b=0xFFFF -> ROUND=0 gives d=0x8000, ROUND=1 gives d=0x8001. Also a=0xFFFF (-1), b=0x0001 -> ROUND=0 gives d=0xFFFF, ROUND=1 gives d=0x0000.
- RADIX=2 and RADIX=4 with in_valid held high and 3 queued requests on channels 0,1,2:
  - out_valid spacing is exactly 9 / 5 cen edges;
  - b=0x0000 still takes full latency;
  - results match a reference model for 10k random a/b/SIGNED/ROUND combinations.
- cen toggled randomly at 30% duty during RUN and DONE -> results identical to cen=1 run; out_valid width equals DONE dwell; no request accepted on cen=0 edges.
- rst asserted 3 steps into RUN, and also during DONE -> next edge: IDLE, out_valid=0, bank all zero, d=0. A request accepted right after reset completes normally.

Source files
------------

// File: rtl/jt08_adpcm_rmul_mch.sv
// jt08_adpcm_rmul_mch
// Multi-channel fractional multiplier computing d = a*b/2^DW. b is consumed
// RADIX bits per cen step, LSB first, into an exact (2*DW+1)-bit accumulator,
// so no precision is lost before the final rounding and shift. a may be read
// as two's complement (SIGNED=1); b is always an unsigned fraction. Each result
// is also kept in a per-channel bank so one engine can serve several channels.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high (independent of cen)
//   cen        clock enable; all state advances only on edges with cen=1
//   in_valid   request present
//   in_ready   engine accepts a request this cycle (IDLE or DONE)
//   in_ch      channel tag of the request
//   a          multiplicand
//   b          unsigned fractional multiplier (b/2^DW)
//   out_valid  result strobe, high for one cen period (DONE state)
//   out_ch     channel tag of d
//   d          result, held until the next completion
//   bank       last result per channel, channel n at [n*DW +: DW]
//   busy       high while the multiply is running
module jt08_adpcm_rmul_mch #(
    parameter int DW     = 16,
    parameter int CH     = 6,
    parameter int CW     = 3,
    parameter int RADIX  = 1,
    parameter int SIGNED = 0,
    parameter int ROUND  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW-1:0]    in_ch,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    output logic             out_valid,
    output logic [CW-1:0]    out_ch,
    output logic [DW-1:0]    d,
    output logic [CH*DW-1:0] bank,
    output logic             busy
);

    localparam int N    = DW / RADIX;
    localparam int CNTW = $clog2(N + 1);
    localparam int AW   = 2 * DW + 1;
    localparam logic [CNTW-1:0] STEPS = CNTW'(N);
    localparam logic [AW-1:0]   RND   = (ROUND != 0) ? (AW'(1) << (DW - 1)) : AW'(0);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [CNTW-1:0]   r_cnt;
    logic [AW-1:0]     r_acc;
    logic [AW-1:0]     r_mcand;
    logic [DW-1:0]     r_mul;
    logic [CW-1:0]     r_ch;
    logic [DW-1:0]     r_d;
    logic [CW-1:0]     r_out_ch;
    logic [DW-1:0]     r_bank [CH];

    logic [AW-1:0]     w_a_ext;
    logic [AW-1:0]     w_partial;
    logic [AW-1:0]     w_acc_nxt;
    logic [AW-1:0]     w_sum;
    logic [DW-1:0]     w_res;
    logic              w_accept;
    logic              w_last;
    logic              w_unused_sum;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state (only cen edges move the machine)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (cen) begin
            case (r_state)
                ST_IDLE: if (in_valid) w_state_nxt = ST_RUN;
                ST_RUN:  if (r_cnt == CNTW'(1)) w_state_nxt = ST_DONE;
                ST_DONE: w_state_nxt = in_valid ? ST_RUN : ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b1;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_RUN: begin
                in_ready = 1'b0;
                busy     = 1'b1;
            end
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    assign w_accept = cen & in_valid & in_ready;
    assign w_last   = busy & (r_cnt == CNTW'(1));

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // Multiplicand widened to the accumulator width; sign-extended only in
    // signed mode. All later arithmetic is modulo 2^AW, which is exact
    // because the true product always fits in AW signed bits.
    assign w_a_ext = {{(DW + 1){(SIGNED != 0) & a[DW-1]}}, a};

    // Contribution of the current RADIX-bit digit of b (shift-add).
    always_comb begin
        w_partial = '0;
        for (int unsigned j = 0; j < RADIX; j++) begin
            if (r_mul[j]) begin
                w_partial = w_partial + (r_mcand << j);
            end
        end
    end

    assign w_acc_nxt = r_acc + w_partial;
    assign w_sum     = w_acc_nxt + RND;
    // Taking bits [2*DW-1:DW] of the two's complement sum is floor(sum/2^DW)
    // in both signed and unsigned modes; the result is known to fit.
    assign w_res        = w_sum[2*DW-1:DW];
    assign w_unused_sum = ^{w_sum[AW-1:2*DW], w_sum[DW-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mul    <= '0;
            r_ch     <= '0;
            r_d      <= '0;
            r_out_ch <= '0;
            for (int unsigned n = 0; n < CH; n++) begin
                r_bank[n] <= '0;
            end
        end else if (cen) begin
            if (w_accept) begin
                r_mcand <= w_a_ext;
                r_mul   <= b;
                r_cnt   <= STEPS;
                r_acc   <= '0;
                r_ch    <= in_ch;
            end else if (busy) begin
                r_acc   <= w_acc_nxt;
                r_mcand <= r_mcand << RADIX;
                r_mul   <= r_mul >> RADIX;
                r_cnt   <= r_cnt - CNTW'(1);
                if (w_last) begin
                    r_d      <= w_res;
                    r_out_ch <= r_ch;
                    // Tags outside the bank range report a result but write nothing.
                    for (int unsigned n = 0; n < CH; n++) begin
                        if (r_ch == CW'(n)) begin
                            r_bank[n] <= w_res;
                        end
                    end
                end
            end
        end
    end

    assign d      = r_d;
    assign out_ch = r_out_ch;

    always_comb begin
        bank = '0;
        for (int unsigned n = 0; n < CH; n++) begin
            bank[n*DW +: DW] = r_bank[n];
        end
    end

endmodule

// File: tb/tb_jt08_adpcm_rmul_mch.sv
`timescale 1ns/1ps
module tb_jt08_adpcm_rmul_mch;

    localparam int NC = 8;
    localparam int DW = 16;
    localparam int CH = 6;
    localparam int CW = 3;

    // Configurations exercised side by side on shared stimulus.
    localparam int C_RADIX  [NC] = '{1, 1, 1, 1, 2, 2, 4, 4};
    localparam int C_SIGNED [NC] = '{0, 0, 1, 1, 1, 0, 1, 0};
    localparam int C_ROUND  [NC] = '{0, 1, 0, 1, 1, 0, 0, 1};
    localparam int C_LAT    [NC] = '{16, 16, 16, 16, 8, 8, 4, 4};
    localparam int C_SPACE  [NC] = '{17, 17, 17, 17, 9, 9, 5, 5};

    // Directed vectors and hand-computed results per mode
    // (mode = 2*SIGNED + ROUND: U-floor, U-round, S-floor, S-round).
    localparam logic [15:0] DIR_A  [6] = '{16'h8000, 16'hFFFF, 16'h0003, 16'h8000, 16'hFFFF, 16'h1234};
    localparam logic [15:0] DIR_B  [6] = '{16'h8000, 16'hFFFF, 16'h8000, 16'hFFFF, 16'h0001, 16'h0000};
    localparam logic [2:0]  DIR_CH [6] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd7};
    localparam logic [15:0] DIR_EXP [24] = '{
        16'h4000, 16'h4000, 16'hC000, 16'hC000,
        16'hFFFE, 16'hFFFE, 16'hFFFF, 16'hFFFF,
        16'h0001, 16'h0002, 16'h0001, 16'h0002,
        16'h7FFF, 16'h8000, 16'h8000, 16'h8001,
        16'h0000, 16'h0001, 16'hFFFF, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        cen;
    logic        in_valid;
    logic [2:0]  in_ch;
    logic [15:0] a;
    logic [15:0] b;

    logic        rdy_a  [NC];
    logic        ov_a   [NC];
    logic        busy_a [NC];
    logic [2:0]  och_a  [NC];
    logic [15:0] d_a    [NC];
    logic [95:0] bank_a [NC];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NC; g++) begin : G
        jt08_adpcm_rmul_mch #(
            .DW     (DW),
            .CH     (CH),
            .CW     (CW),
            .RADIX  (C_RADIX[g]),
            .SIGNED (C_SIGNED[g]),
            .ROUND  (C_ROUND[g])
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .cen       (cen),
            .in_valid  (in_valid),
            .in_ready  (rdy_a[g]),
            .in_ch     (in_ch),
            .a         (a),
            .b         (b),
            .out_valid (ov_a[g]),
            .out_ch    (och_a[g]),
            .d         (d_a[g]),
            .bank      (bank_a[g]),
            .busy      (busy_a[g])
        );
    end

    // ------------------------------------------------------------------
    // Reference arithmetic: exact product in a 64-bit integer
    // ------------------------------------------------------------------
    function automatic logic [15:0] calc(input logic [15:0] av, input logic [15:0] bv,
                                         input int sg, input int rd);
        longint aa;
        longint p;
        aa = (sg != 0) ? longint'($signed(av)) : longint'(av);
        p  = aa * longint'(bv);
        if (rd != 0) p = p + 64'sd32768;
        p = p >>> 16;
        return p[15:0];
    endfunction

    // ------------------------------------------------------------------
    // Timeline model: an op accepted at cen edge k completes at edge k+LAT,
    // the engine refuses new work on edges k+1..k+LAT, results and bank
    // update at edge k+LAT and the strobe lasts until the next cen edge.
    // ------------------------------------------------------------------
    int          m_e;
    int          m_due  [NC];
    logic        m_ov   [NC];
    logic [15:0] m_d    [NC];
    logic [2:0]  m_och  [NC];
    logic [15:0] m_bank [NC][CH];
    logic [15:0] p_res  [NC];
    logic [2:0]  p_ch   [NC];

    always @(posedge clk) begin
        if (rst) begin
            m_e = 0;
            for (int g = 0; g < NC; g++) begin
                m_due[g] = -1;
                m_ov[g]  = 1'b0;
                m_d[g]   = '0;
                m_och[g] = '0;
                for (int c = 0; c < CH; c++) m_bank[g][c] = '0;
            end
        end else if (cen) begin
            m_e = m_e + 1;
            for (int g = 0; g < NC; g++) begin
                m_ov[g] = (m_e == m_due[g]);
                if (m_ov[g]) begin
                    m_d[g]   = p_res[g];
                    m_och[g] = p_ch[g];
                    if (int'(p_ch[g]) < CH) m_bank[g][p_ch[g]] = p_res[g];
                end
                if (m_due[g] < m_e && in_valid) begin
                    m_due[g] = m_e + C_LAT[g];
                    p_res[g] = calc(a, b, C_SIGNED[g], C_ROUND[g]);
                    p_ch[g]  = in_ch;
                end
            end
        end
    end

    int tb_edges = 0;
    always @(posedge clk) if (cen) tb_edges <= tb_edges + 1;

    // ------------------------------------------------------------------
    // Compare process
    // ------------------------------------------------------------------
    int   n_checks = 0;
    int   n_errors = 0;
    logic chk_en   = 1'b0;
    logic lat_chk  = 1'b0;
    logic bb_chk   = 1'b0;
    logic dir_chk  = 1'b0;
    logic bank_chk = 1'b0;
    logic rst_chk  = 1'b0;
    int   dir_v    = 0;
    int   ref_edge = 0;

    logic prev_ov   [NC];
    int   last_rise [NC];
    logic have_last [NC];

    task automatic chk(input string name, input int g, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cfg%0d: got %h expected %h at %0t", name, g, act, exp, $time);
        end
    endtask

    logic [95:0] eb;
    logic        ebusy;
    int          mode;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < NC; g++) begin
                mode  = C_SIGNED[g] * 2 + C_ROUND[g];
                ebusy = (m_due[g] >= m_e + 1);
                for (int c = 0; c < CH; c++) eb[c*16 +: 16] = m_bank[g][c];
                chk("status", g, 128'({ov_a[g], rdy_a[g], busy_a[g]}), 128'({m_ov[g], ~ebusy, ebusy}));
                chk("d", g, 128'(d_a[g]), 128'(m_d[g]));
                chk("out_ch", g, 128'(och_a[g]), 128'(m_och[g]));
                chk("bank", g, 128'(bank_a[g]), 128'(eb));
                if (ov_a[g] && !prev_ov[g]) begin
                    if (lat_chk) chk("latency", g, 128'(tb_edges - ref_edge), 128'(C_LAT[g]));
                    if (bb_chk && have_last[g])
                        chk("spacing", g, 128'(tb_edges - last_rise[g]), 128'(C_SPACE[g]));
                    last_rise[g] = tb_edges;
                    have_last[g] = bb_chk;
                end
                prev_ov[g] = ov_a[g];
                if (dir_chk) chk("dir_d", g, 128'(d_a[g]), 128'(DIR_EXP[dir_v*4 + mode]));
                if (bank_chk) chk("dir_bank", g, 128'(bank_a[g]), 128'({48'h0, DIR_EXP[mode], 32'h0}));
                if (rst_chk)
                    chk("rst_state", g,
                        128'({ov_a[g], rdy_a[g], busy_a[g], d_a[g], och_a[g], bank_a[g]}),
                        128'({1'b0, 1'b1, 1'b0, 16'h0, 3'h0, 96'h0}));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic dir_op(input int v);
        in_valid = 1'b1;
        a        = DIR_A[v];
        b        = DIR_B[v];
        in_ch    = DIR_CH[v];
        step();
        in_valid = 1'b0;
        ref_edge = tb_edges;
        a        = 16'($urandom);
        b        = 16'($urandom);
        repeat (17) step();
        dir_v    = v;
        dir_chk  = 1'b1;
        bank_chk = (v == 0);
        step();
        dir_chk  = 1'b0;
        bank_chk = 1'b0;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step();
        rst     = 1'b0;
        rst_chk = 1'b1;
        step();
        rst_chk = 1'b0;
    endtask

    initial begin
        for (int g = 0; g < NC; g++) begin
            prev_ov[g]   = 1'b0;
            last_rise[g] = 0;
            have_last[g] = 1'b0;
        end
        rst      = 1'b1;
        cen      = 1'b0;
        in_valid = 1'b0;
        in_ch    = '0;
        a        = '0;
        b        = '0;

        // Reset must act even with cen low.
        repeat (3) step();
        chk_en  = 1'b1;
        rst     = 1'b0;
        cen     = 1'b1;
        rst_chk = 1'b1;
        step();
        rst_chk = 1'b0;

        // Directed vectors with latency measurement.
        lat_chk = 1'b1;
        for (int v = 0; v < 6; v++) dir_op(v);

        // Reset three steps into RUN, then a fresh request.
        in_valid = 1'b1;
        a        = 16'($urandom);
        b        = 16'($urandom);
        in_ch    = 3'd1;
        step();
        in_valid = 1'b0;
        ref_edge = tb_edges;
        repeat (3) step();
        reset_pulse();
        dir_op(3);

        // Reset while the RADIX-1 engines sit in DONE.
        in_valid = 1'b1;
        a        = 16'($urandom);
        b        = 16'($urandom);
        in_ch    = 3'd0;
        step();
        in_valid = 1'b0;
        ref_edge = tb_edges;
        repeat (16) step();
        reset_pulse();
        dir_op(1);
        lat_chk = 1'b0;

        // Back-to-back requests with in_valid held high.
        bb_chk   = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a     = 16'($urandom);
            b     = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            in_ch = 3'($urandom_range(0, 2));
            step();
        end
        in_valid = 1'b0;
        bb_chk   = 1'b0;
        repeat (20) step();

        // Random traffic: first with sparse cen, then mostly-on cen.
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < (ph == 0 ? 12000 : 24000); i++) begin
                cen      = (ph == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) != 0);
                in_valid = ($urandom_range(0, 9) < 7);
                a        = pick();
                b        = pick();
                in_ch    = 3'($urandom_range(0, 7));
                rst      = ($urandom_range(0, 2999) == 0);
                step();
            end
        end
        rst      = 1'b0;
        cen      = 1'b1;
        in_valid = 1'b0;
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
